// File: rtl/instr_fetch.sv
// instr_fetch: two-state (IDLE/WAIT) instruction fetch unit with PC, IR and pending-branch tracking.
// Define FETCH_TIMEOUT_EN to abort fetches that wait TIMEOUT_CYC cycles without an ack.
module instr_fetch #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        fetch_go,
    input  logic        br_load,
    input  logic [15:0] br_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [15:0] pc,
    output logic        busy,
    output logic        fetch_fault
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      r_state, w_state_nxt;
    logic        r_imem_req, r_ir_valid, r_fault, r_br_pend;
    logic [15:0] r_imem_addr, r_pc, r_br_addr;
    logic [31:0] r_ir;
    logic        w_ack, w_timeout, w_take_br;
    logic [15:0] w_br_tgt;

    assign w_ack     = (r_state == WAIT) && imem_ack;
    assign w_take_br = br_load || r_br_pend;
    assign w_br_tgt  = br_load ? br_addr : r_br_addr;

`ifdef FETCH_TIMEOUT_EN
    logic [15:0] r_cnt;
    // An ack in the final counted cycle takes priority over the timeout.
    assign w_timeout = (r_state == WAIT) && !imem_ack && (r_cnt == 16'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) r_cnt <= '0;
        else        r_cnt <= (r_state == WAIT && !w_ack && !w_timeout) ? r_cnt + 16'd1 : '0;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE && fetch_go) w_state_nxt = WAIT;
        if (w_ack || w_timeout)          w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_fault     <= 1'b0;
            r_pc        <= RESET_PC;
            r_br_pend   <= 1'b0;
            r_br_addr   <= '0;
        end else begin
            r_ir_valid <= w_ack;
            r_fault    <= w_timeout;
            if (r_state == IDLE) begin
                if (br_load) r_pc <= br_addr;
                if (fetch_go) begin
                    r_imem_req  <= 1'b1;
                    r_imem_addr <= br_load ? br_addr : r_pc;
                end
            end else begin
                if (w_ack) begin
                    r_ir <= imem_rdata;
                    r_pc <= w_take_br ? w_br_tgt : r_pc + 16'd1;
                end
                if (w_timeout) r_ir <= '0;
                if (w_ack || w_timeout) begin
                    r_imem_req <= 1'b0;
                    r_br_pend  <= 1'b0;
                end else if (br_load) begin
                    r_br_pend <= 1'b1;
                    r_br_addr <= br_addr;
                end
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign ir          = r_ir;
    assign ir_valid    = r_ir_valid;
    assign pc          = r_pc;
    assign busy        = (r_state == WAIT);
    assign fetch_fault = r_fault;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with a scoreboard queue of expected {ir, pc} per ir_valid pulse.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_f, fetch_go, br_load, imem_ack;
    logic [15:0] br_addr;
    logic [31:0] imem_rdata;
    logic        imem_req, ir_valid, busy, fetch_fault;
    logic [15:0] imem_addr, pc;
    logic [31:0] ir;

    typedef struct {
        logic [31:0] ir;
        logic [15:0] pc;
    } exp_t;
    exp_t q[$];
    int total = 0;
    int bad   = 0;

    instr_fetch #(.RESET_PC(16'h0000), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_f(rst_f), .fetch_go(fetch_go), .br_load(br_load), .br_addr(br_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .imem_req(imem_req), .imem_addr(imem_addr),
        .ir(ir), .ir_valid(ir_valid), .pc(pc), .busy(busy), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] e_ir, input logic [15:0] e_pc);
        exp_t e;
        e.ir = e_ir;
        e.pc = e_pc;
        q.push_back(e);
    endtask

    task automatic ack(input logic [31:0] data, input logic [15:0] e_pc);
        imem_ack   = 1'b1;
        imem_rdata = data;
        push(data, e_pc);
        tick();
        imem_ack = 1'b0;
    endtask

    // Monitor: every ir_valid must match the oldest expected completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ir_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ir_valid: got ir=%h pc=%h expected no pulse", ir, pc);
                end else begin
                    e = q.pop_front();
                    chk("mon_ir", ir, e.ir);
                    chk("mon_pc", {16'h0, pc}, {16'h0, e.pc});
                end
            end
        end
    end

    initial begin
        rst_f = 1'b0; fetch_go = 1'b0; br_load = 1'b0; br_addr = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        tick(); tick();
        chk("rst_outputs", {imem_req, ir_valid, busy, fetch_fault}, 4'b0000);
        chk("rst_addr_pc", {imem_addr, pc}, 32'h0);
        chk("rst_ir", ir, 32'h0);
        rst_f = 1'b1;
        tick();
        // basic fetch, ack one cycle after req
        fetch_go = 1'b1; tick(); fetch_go = 1'b0;
        chk("req_after_go", {imem_req, busy}, 2'b11);
        chk("addr_after_go", imem_addr, 32'h0);
        ack(32'h1234_5678, 16'h0001);
        chk("req_drop", {imem_req, busy}, 2'b00);
        tick(); tick();
        chk("ir_hold", ir, 32'h1234_5678);
        // ack while IDLE is ignored
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_ack = 1'b0;
        chk("idle_ack_ir", ir, 32'h1234_5678);
        chk("idle_ack_pc", pc, 32'h0001);
        // fetch_go during WAIT is not queued
        fetch_go = 1'b1; tick(); tick(); fetch_go = 1'b0;
        chk("wait_addr_hold", imem_addr, 32'h0001);
        ack(32'hAAAA_0001, 16'h0002);
        tick();
        chk("go_not_queued", busy, 1'b0);
        // fetch_go + br_load in IDLE
        fetch_go = 1'b1; br_load = 1'b1; br_addr = 16'h0100; tick();
        fetch_go = 1'b0; br_load = 1'b0;
        chk("br_go_addr", imem_addr, 32'h0100);
        chk("br_go_pc", pc, 32'h0100);
        ack(32'hBBBB_0002, 16'h0101);
        // br_load only in IDLE
        br_load = 1'b1; br_addr = 16'h0010; tick(); br_load = 1'b0;
        chk("br_idle_pc", pc, 32'h0010);
        chk("br_idle_busy", busy, 1'b0);
        // pending branch during WAIT, last one wins
        fetch_go = 1'b1; tick(); fetch_go = 1'b0;
        br_load = 1'b1; br_addr = 16'h0030; tick();
        br_addr = 16'h0040; tick(); br_load = 1'b0;
        chk("pend_req_hold", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0010});
        ack(32'hCCCC_0003, 16'h0040);
        // pc wrap
        br_load = 1'b1; br_addr = 16'hFFFF; tick(); br_load = 1'b0;
        fetch_go = 1'b1; tick(); fetch_go = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF);
        ack(32'hDDDD_0004, 16'h0000);
        // reset during WAIT aborts the fetch
        fetch_go = 1'b1; tick(); fetch_go = 1'b0;
        chk("pre_rst_busy", busy, 1'b1);
        rst_f = 1'b0; #1;
        chk("async_rst", {imem_req, busy, ir_valid}, 3'b000);
        chk("async_rst_ir", ir, 32'h0);
        tick(); rst_f = 1'b1;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hEEEE_0005; tick(); imem_ack = 1'b0;
        tick();
        chk("post_rst_ir", ir, 32'h0);
        chk("post_rst_req", imem_req, 1'b0);
`ifdef FETCH_TIMEOUT_EN
        // ack in the 16th WAIT cycle wins over the timeout
        fetch_go = 1'b1; tick(); fetch_go = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        ack(32'hFFFF_0006, 16'h0001);
        chk("ack_wins_fault", fetch_fault, 1'b0);
        // no ack: fault after 16 WAIT cycles
        fetch_go = 1'b1; tick(); fetch_go = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("to_still_busy", {busy, fetch_fault}, 2'b10);
        tick();
        chk("to_fault", {fetch_fault, busy, imem_req}, 3'b100);
        chk("to_ir", ir, 32'h0);
        chk("to_pc", pc, 32'h0001);
        tick();
        chk("to_fault_pulse", fetch_fault, 1'b0);
`endif
        tick(); tick();
        chk("queue_empty", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
